// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: valid/ready handshake, stall hold, flush-to-bubble.
// Optional starvation counter on bubble_cnt, enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_reg #(
  parameter int               WIDTH         = 32,
  parameter logic [WIDTH-1:0] RESET_VAL     = 32'h00000013,
  parameter logic             RESET_VALID   = 1'b0,
  parameter logic [WIDTH-1:0] BUBBLE_VAL    = 32'h00000013,
  parameter bit               HOLD_ON_STALL = 1'b0,
  parameter int               CNT_W         = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             load;

  assign in_ready = !reset && !flush && !stall && (!valid_q || out_ready);
  assign load     = in_valid && in_ready;

  // Priority: flush > stall > load > drain; load also covers drain+refill in one cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      data_d  = BUBBLE_VAL;
      valid_d = 1'b0;
    end else if (!stall) begin
      if (load) begin
        data_d  = in_data;
        valid_d = 1'b1;
      end else if (valid_q && out_ready) begin
        data_d  = BUBBLE_VAL;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= RESET_VAL;
      valid_q <= RESET_VALID;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  // PC-style stages keep presenting the stored value through a stall.
  generate
    if (HOLD_ON_STALL) begin : g_hold
      assign out_valid = valid_q;
      assign out_data  = valid_q ? data_q : BUBBLE_VAL;
    end else begin : g_bubble
      assign out_valid = valid_q && !stall;
      assign out_data  = out_valid ? data_q : BUBBLE_VAL;
    end
  endgenerate

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_ready && !out_valid && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;
`else
  assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: NOP-bubble data stage (table-driven) plus a PC-mode stage.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, stall, flush, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [3:0]  bubble_cnt;

  logic        pc_in_valid, pc_stall, pc_flush, pc_out_ready;
  logic [31:0] pc_in_data;
  logic        pc_in_ready, pc_out_valid;
  logic [31:0] pc_out_data;
  logic [15:0] pc_bubble_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CNT_W(4)) u_dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(
    .RESET_VAL(32'h00001FFC), .RESET_VALID(1'b1), .HOLD_ON_STALL(1'b1)
  ) u_pc (
    .clk(clk), .reset(reset),
    .in_valid(pc_in_valid), .in_data(pc_in_data), .in_ready(pc_in_ready),
    .stall(pc_stall), .flush(pc_flush),
    .out_valid(pc_out_valid), .out_data(pc_out_data), .out_ready(pc_out_ready),
    .bubble_cnt(pc_bubble_cnt)
  );

`ifdef PIPE_STAGE_PERF_EN
  localparam logic [31:0] EXP_CNT5  = 32'd5;
  localparam logic [31:0] EXP_CNT20 = 32'd15;
`else
  localparam logic [31:0] EXP_CNT5  = 32'd0;
  localparam logic [31:0] EXP_CNT20 = 32'd0;
`endif

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        st;
    logic        fl;
    logic        ordy;
    logic        exp_rdy;   // in_ready before the edge
    logic        exp_ov;    // out_valid after the edge
    logic [31:0] exp_od;    // out_data after the edge
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    // iv  id           st    fl    ordy  rdy   ov    od
    vecs[0]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA0};
    vecs[1]  = '{1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA1};
    vecs[2]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA2};
    vecs[3]  = '{1'b1, 32'hA3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA3};
    vecs[4]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h13};
    vecs[5]  = '{1'b1, 32'hA0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA0};
    vecs[6]  = '{1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0};
    vecs[7]  = '{1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0};
    vecs[8]  = '{1'b1, 32'hB0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0};
    vecs[9]  = '{1'b1, 32'hB0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB0};
    vecs[10] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h13};
    vecs[11] = '{1'b1, 32'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA5};
    vecs[12] = '{1'b1, 32'hD0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h13};
    vecs[13] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h13};
    vecs[14] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA5};
    vecs[15] = '{1'b1, 32'hC0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13};
    vecs[16] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h13};
    vecs[17] = '{1'b1, 32'hE0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hE0};
    vecs[18] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h13};
    vecs[19] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h13};

    reset = 1'b1;
    in_valid = 1'b0; in_data = '0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    pc_in_valid = 1'b0; pc_in_data = '0; pc_stall = 1'b0; pc_flush = 1'b0; pc_out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_low", in_ready, 0);
    chk("rst_pc_in_ready_low", pc_in_ready, 0);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 32'h13);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bubble_cnt", bubble_cnt, 0);
    chk("pc_rst_out_valid", pc_out_valid, 1);
    chk("pc_rst_out_data", pc_out_data, 32'h1FFC);
    chk("pc_rst_in_ready_full", pc_in_ready, 0);
    $display("reset released: out_valid=%0b out_data=%h pc_out=%h", out_valid, out_data, pc_out_data);

    // Empty stage, downstream ready: every edge is a starvation cycle.
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("bubble_cnt_5", bubble_cnt, EXP_CNT5);
    repeat (15) @(posedge clk);
    #1;
    chk("bubble_cnt_20_sat", bubble_cnt, EXP_CNT20);
    $display("starvation: bubble_cnt=%0d after 20 cycles", bubble_cnt);

    for (int i = 0; i < 20; i++) begin
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].id;
      stall     = vecs[i].st;
      flush     = vecs[i].fl;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), out_valid, vecs[i].exp_ov);
      chk($sformatf("v%0d_out_data", i), out_data, vecs[i].exp_od);
      $display("vec %0d: iv=%0b id=%h st=%0b fl=%0b ordy=%0b -> ov=%0b od=%h",
               i, vecs[i].iv, vecs[i].id, vecs[i].st, vecs[i].fl, vecs[i].ordy,
               out_valid, out_data);
    end
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0; out_ready = 1'b0;
    chk("bubble_cnt_end", bubble_cnt, EXP_CNT20);

    // PC mode: reset value held while not consumed, then advance, then stall keeps value visible.
    pc_in_valid = 1'b1; pc_in_data = 32'h2000; pc_out_ready = 1'b1;
    #1;
    chk("pc_in_ready_advance", pc_in_ready, 1);
    @(posedge clk);
    #1;
    chk("pc_load_valid", pc_out_valid, 1);
    chk("pc_load_data", pc_out_data, 32'h2000);
    $display("pc: loaded %h", pc_out_data);

    pc_in_data = 32'h2004; pc_stall = 1'b1;
    #1;
    chk("pc_stall_in_ready", pc_in_ready, 0);
    chk("pc_stall_comb_valid", pc_out_valid, 1);
    @(posedge clk);
    #1;
    chk("pc_stall_hold_valid", pc_out_valid, 1);
    chk("pc_stall_hold_data", pc_out_data, 32'h2000);
    $display("pc: stalled at %h", pc_out_data);

    pc_stall = 1'b0;
    #1;
    chk("pc_unstall_in_ready", pc_in_ready, 1);
    @(posedge clk);
    #1;
    chk("pc_resume_data", pc_out_data, 32'h2004);
    $display("pc: resumed %h", pc_out_data);

    pc_in_valid = 1'b0; pc_flush = 1'b1;
    @(posedge clk);
    #1;
    pc_flush = 1'b0;
    chk("pc_flush_valid", pc_out_valid, 0);
    chk("pc_flush_data", pc_out_data, 32'h13);
    $display("pc: flushed, out=%h", pc_out_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
